reconf_tile_pipe: RTL



---
 rtl/reconf_tile_pkg.sv | 39 +++
 rtl/new_fp16_add.sv | 72 +++++++
 rtl/new_fp16_mul.sv | 51 +++++
 rtl/reconf_add_level.sv | 63 ++++++
 rtl/reconf_tile_pipe.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/reconf_tile_pkg.sv
// reconf_tile_pkg
// Shared types and helpers for the pipelined FP16 tile.
//   mode_e       operation select carried down the pipeline
//   acc_state_e  dot-product accumulator states
//   side_t       per-beat sideband travelling alongside the adder tree
//   FP16_ZERO    positive zero
//   tree_depth   log2 of a power-of-two lane count
package reconf_tile_pkg;

    typedef enum logic [1:0] {
        VEC     = 2'd0,
        SCAL    = 2'd1,
        DOT     = 2'd2,
        DOT_ACC = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic  valid;
        logic  last;
        mode_e mode;
    } side_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    function automatic int tree_depth(input int n);
        int d;
        d = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) d = i + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/new_fp16_add.sv
// new_fp16_add
// Combinational FP16 adder, round-to-nearest-even with guard/round/sticky.
// Denormals flush to zero; an infinite/NaN operand passes through.
//   a, b  operands
//   y     sum
module new_fp16_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic [15:0] big;
    logic [15:0] sml;
    logic [4:0]  diff;
    logic [13:0] mb;
    logic [13:0] ms;
    logic        stk;
    logic [14:0] sum;
    logic [5:0]  e;
    logic [10:0] mant;

    always_comb begin
        if (a[14:0] >= b[14:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        diff = big[14:10] - sml[14:10];
        // hidden bit, 10 fraction bits, 3 bits of guard/round/sticky
        mb   = {1'b1, big[9:0], 3'b000};
        ms   = {1'b1, sml[9:0], 3'b000};
        stk  = 1'b0;
        for (int i = 0; i < 31; i++) begin
            if (i < int'(diff)) begin
                stk = stk | ms[0];
                ms  = ms >> 1;
            end
        end
        ms[0] = ms[0] | stk;
        e     = {1'b0, big[14:10]};
        if (big[15] == sml[15]) sum = {1'b0, mb} + {1'b0, ms};
        else                    sum = {1'b0, mb} - {1'b0, ms};
        if (sum[14]) begin
            sum = {1'b0, sum[14:2], sum[1] | sum[0]};
            e   = e + 6'd1;
        end
        for (int i = 0; i < 13; i++) begin
            if (!sum[13] && e > 6'd1) begin
                sum = sum << 1;
                e   = e - 6'd1;
            end
        end
        mant = {1'b0, sum[12:3]};
        if (sum[2] && (sum[1] || sum[0] || sum[3])) mant = mant + 11'd1;
        if (mant[10]) begin
            mant = 11'd0;
            e    = e + 6'd1;
        end
        y = {big[15], e[4:0], mant[9:0]};
        // hidden bit still clear after normalising: cancellation or underflow
        if (!sum[13])
            y = 16'h0000;
        else if (e >= 6'd31)
            y = {big[15], 5'h1f, 10'h000};
        if (sml[14:10] == 5'd0)  y = big;
        if (big[14:10] == 5'h1f) y = big;
        if (big[14:10] == 5'd0)  y = {a[15] & b[15], 15'h0000};
    end

endmodule

// File: rtl/new_fp16_mul.sv
// new_fp16_mul
// Combinational FP16 multiplier, round-to-nearest-even.
// Denormal operands and results flush to signed zero; any infinite/NaN
// operand or exponent overflow yields a signed infinity.
//   a, b  operands
//   y     product
module new_fp16_mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic              sign;
    logic [21:0]       prod;
    logic              norm_hi;
    logic [10:0]       mant;
    logic              rnd;
    logic              stk;
    logic signed [7:0] exp_v;

    always_comb begin
        sign    = a[15] ^ b[15];
        prod    = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        norm_hi = prod[21];
        exp_v   = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        if (norm_hi) begin
            exp_v = exp_v + 8'sd1;
            mant  = {1'b0, prod[20:11]};
            rnd   = prod[10];
            stk   = |prod[9:0];
        end else begin
            mant  = {1'b0, prod[19:10]};
            rnd   = prod[9];
            stk   = |prod[8:0];
        end
        if (rnd && (stk || mant[0])) mant = mant + 11'd1;
        // rounding 1.11..1 up gives 2.0: mantissa wraps, exponent steps
        if (mant[10]) begin
            mant  = 11'd0;
            exp_v = exp_v + 8'sd1;
        end
        y = {sign, exp_v[4:0], mant[9:0]};
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0)
            y = {sign, 15'h0000};
        else if (a[14:10] == 5'h1f || b[14:10] == 5'h1f || exp_v >= 8'sd31)
            y = {sign, 5'h1f, 10'h000};
        else if (exp_v <= 8'sd0)
            y = {sign, 15'h0000};
    end

endmodule

// File: rtl/reconf_add_level.sv
// reconf_add_level
// One registered level of the pairwise FP16 adder tree. Lane j of the output
// is the sum of input lanes 2j and 2j+1. The sideband bits and the product
// vector delay line are registered alongside so every beat stays aligned.
// With USE_LOAD set the sum register captures sum_load instead of the local
// pair sums; the final level uses this to insert the accumulator result.
//   clk, rst        clock, async active-high reset
//   en              pipeline advance; all registers hold when low
//   sum_in          N_IN lanes from the previous level
//   sum_load        replacement register input (USE_LOAD only)
//   side_in/side_q  sideband bits in/registered
//   vec_in/vec_q    product vector delay line in/registered
//   sum_comb        unregistered pair sums
//   sum_q           registered level result
module reconf_add_level
    import reconf_tile_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int DATA_W   = 16,
    parameter int VEC_W    = 32,
    parameter int SB_W     = 4,
    parameter bit USE_LOAD = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_IN*DATA_W-1:0]       sum_in,
    input  logic [(N_IN/2)*DATA_W-1:0]   sum_load,
    input  logic [SB_W-1:0]              side_in,
    input  logic [VEC_W-1:0]             vec_in,
    output logic [(N_IN/2)*DATA_W-1:0]   sum_comb,
    output logic [(N_IN/2)*DATA_W-1:0]   sum_q,
    output logic [SB_W-1:0]              side_q,
    output logic [VEC_W-1:0]             vec_q
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*DATA_W-1:0] sum_d;

    for (genvar j = 0; j < N_OUT; j++) begin : g_add
        new_fp16_add u_add (
            .a (sum_in[(2*j)*DATA_W +: DATA_W]),
            .b (sum_in[(2*j+1)*DATA_W +: DATA_W]),
            .y (sum_comb[j*DATA_W +: DATA_W])
        );
    end

    assign sum_d = USE_LOAD ? sum_load : sum_comb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            side_q <= '0;
            vec_q  <= '0;
        end else if (en) begin
            sum_q  <= sum_d;
            side_q <= side_in;
            vec_q  <= vec_in;
        end
    end

endmodule

// File: rtl/reconf_tile_pipe.sv
// reconf_tile_pipe
// Pipelined reconfigurable FP16 tile: element-wise or vector-by-scalar
// products, optional reduction through a registered adder tree and optional
// accumulation of dot products across beats. Latency 1 + log2(TILE_SIZE).
// A single advance signal stalls every stage together.
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    input handshake
//   in_mode              VEC=0, SCAL=1, DOT=2, DOT_ACC=3
//   in_last              closes a DOT_ACC group
//   vec1, vec2, scal     operands (lane i at [i*DATA_W +: DATA_W])
//   out_valid/out_ready  output handshake
//   o_vec, o_scal        product vector, reduction result
//
// Accumulator FSM
//   state | meaning
//   IDLE  | no open DOT_ACC group, acc is zero
//   ACCUM | group open, acc holds the running sum of its beats
module reconf_tile_pipe
    import reconf_tile_pkg::*;
#(
    parameter int TILE_SIZE = 128,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_mode,
    input  logic                        in_last,
    input  logic [TILE_SIZE*DATA_W-1:0] vec1,
    input  logic [TILE_SIZE*DATA_W-1:0] vec2,
    input  logic [DATA_W-1:0]           scal,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TILE_SIZE*DATA_W-1:0] o_vec,
    output logic [DATA_W-1:0]           o_scal
);

    localparam int LAT   = 1 + tree_depth(TILE_SIZE);
    localparam int DEPTH = LAT - 1;
    localparam int VEC_W = TILE_SIZE * DATA_W;

    logic              advance;
    logic [VEC_W-1:0]  prod_d;
    logic [VEC_W-1:0]  prod_q;
    side_t             s1_side;

    side_t             fin_pre_side;
    logic [DATA_W-1:0] fin_pre_sum;
    logic [VEC_W-1:0]  fin_pre_vec;
    logic [DATA_W-1:0] fin_load;
    logic              fin_valid_in;
    logic [VEC_W-1:0]  fin_vec_in;
    logic              fin_is_acc;

    acc_state_e        acc_state;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_sum;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar i = 0; i < TILE_SIZE; i++) begin : g_mul
        logic [DATA_W-1:0] opb;
        assign opb = (in_mode == SCAL) ? scal : vec2[i*DATA_W +: DATA_W];
        new_fp16_mul u_mul (
            .a (vec1[i*DATA_W +: DATA_W]),
            .b (opb),
            .y (prod_d[i*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            s1_side <= '0;
        end else if (advance) begin
            prod_q        <= prod_d;
            s1_side.valid <= in_valid;
            s1_side.last  <= in_last;
            s1_side.mode  <= mode_e'(in_mode);
        end
    end

    // The registered products double as the first tap of the o_vec delay line.
    for (genvar k = 1; k <= DEPTH; k++) begin : g_lvl
        localparam int N_IN  = TILE_SIZE >> (k - 1);
        localparam int N_OUT = N_IN / 2;
        localparam bit FINAL = (k == DEPTH);
        localparam int SB_W  = FINAL ? 1 : $bits(side_t);

        logic [N_IN*DATA_W-1:0]  src_sum;
        side_t                   src_side;
        logic [VEC_W-1:0]        src_vec;
        logic [N_OUT*DATA_W-1:0] sum_load;
        logic [N_OUT*DATA_W-1:0] sum_comb;
        logic [N_OUT*DATA_W-1:0] sum_q;
        logic [SB_W-1:0]         side_in;
        logic [SB_W-1:0]         side_q;
        logic [VEC_W-1:0]        vec_in;
        logic [VEC_W-1:0]        vec_q;

        if (k == 1) begin : g_src
            assign src_sum  = prod_q;
            assign src_side = s1_side;
            assign src_vec  = prod_q;
        end else begin : g_src
            assign src_sum  = g_lvl[k-1].sum_q;
            assign src_side = g_lvl[k-1].side_q;
            assign src_vec  = g_lvl[k-1].vec_q;
        end

        // The last level only needs to carry the output valid; mode and last
        // are consumed here by the accumulator and output muxing.
        if (FINAL) begin : g_fin
            assign fin_pre_sum  = sum_comb;
            assign fin_pre_side = src_side;
            assign fin_pre_vec  = src_vec;
            assign sum_load     = fin_load;
            assign side_in      = fin_valid_in;
            assign vec_in       = fin_vec_in;
        end else begin : g_mid
            assign sum_load = '0;
            assign side_in  = src_side;
            assign vec_in   = src_vec;
        end

        reconf_add_level #(
            .N_IN     (N_IN),
            .DATA_W   (DATA_W),
            .VEC_W    (VEC_W),
            .SB_W     (SB_W),
            .USE_LOAD (FINAL)
        ) u_lvl (
            .clk      (clk),
            .rst      (rst),
            .en       (advance),
            .sum_in   (src_sum),
            .sum_load (sum_load),
            .side_in  (side_in),
            .vec_in   (vec_in),
            .sum_comb (sum_comb),
            .sum_q    (sum_q),
            .side_q   (side_q),
            .vec_q    (vec_q)
        );
    end

    new_fp16_add u_acc_add (
        .a (acc),
        .b (fin_pre_sum),
        .y (acc_sum)
    );

    assign fin_is_acc = fin_pre_side.valid && (fin_pre_side.mode == DOT_ACC);

    // Non-last DOT_ACC beats still flow through to update acc but are not emitted.
    assign fin_valid_in = fin_pre_side.valid &&
                          !((fin_pre_side.mode == DOT_ACC) && !fin_pre_side.last);

    assign fin_vec_in = (fin_pre_side.mode == VEC || fin_pre_side.mode == SCAL) ?
                        fin_pre_vec : '0;

    // In IDLE a closing beat is a single-beat group: emit its sum directly
    // rather than adding it to zero.
    always_comb begin
        fin_load = FP16_ZERO;
        case (fin_pre_side.mode)
            DOT:     fin_load = fin_pre_sum;
            DOT_ACC: fin_load = (acc_state == ACCUM) ? acc_sum : fin_pre_sum;
            default: fin_load = FP16_ZERO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_state <= IDLE;
            acc       <= FP16_ZERO;
        end else if (advance && fin_is_acc) begin
            case (acc_state)
                IDLE: begin
                    if (!fin_pre_side.last) begin
                        acc       <= fin_pre_sum;
                        acc_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (fin_pre_side.last) begin
                        acc       <= FP16_ZERO;
                        acc_state <= IDLE;
                    end else begin
                        acc <= acc_sum;
                    end
                end
                default: acc_state <= IDLE;
            endcase
        end
    end

    assign out_valid = g_lvl[DEPTH].side_q[0];
    assign o_scal    = g_lvl[DEPTH].sum_q;
    assign o_vec     = g_lvl[DEPTH].vec_q;

endmodule
